// File: rtl/arm_pkg.sv
// Shared types and constants for the SRAM path: FSM state encoding, address map and
// the byte-address to SRAM-word translation.
package arm_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} sram_state_t;

    localparam logic [31:0]  SRAM_BASE_ADDR = 32'd1024;
    localparam int unsigned  SRAM_ADDR_W    = 17;
    localparam int unsigned  SRAM_DATA_W    = 32;
    localparam int unsigned  SRAM_CNT_W     = 4;

    // Offset wraps mod 2^32; the byte-lane bits are dropped.
    function automatic logic [SRAM_ADDR_W-1:0] sram_word_addr(input logic [31:0] byte_addr,
                                                              input logic [31:0] base);
        return SRAM_ADDR_W'((byte_addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Access-length counter: cleared on start, counts while active and flags the final
// cycle of an SRAM access.
module sram_wait_counter
    import arm_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    output logic last
);

    localparam logic [SRAM_CNT_W-1:0] LastCount = SRAM_CNT_W'(WAIT_CYCLES - 1);

    logic [SRAM_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (active && !last) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == LastCount);

endmodule

// File: rtl/sram_controller.sv
// Turns one-shot MEM-stage load/store requests into multi-cycle accesses on the external
// async SRAM, freezing the pipeline via ready. Define SRAM_POSTED_WRITE_EN for posted writes.
module sram_controller
    import arm_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_en,
    input  logic                   read_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   SRAM_WE_N
);

    sram_state_t            state_q, state_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic                   is_write_q, is_write_d;
    logic [31:0]            rdata_q;
    logic                   req;
    logic                   start;
    logic                   in_access;
    logic                   last;
    logic                   drive_dq;

    assign req       = write_en | read_en;
    assign start     = (state_q == IDLE) && req;
    assign in_access = (state_q == ACCESS);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .active (in_access),
        .last   (last)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        is_write_d = is_write_q;
        ready      = 1'b0;
        unique case (state_q)
            IDLE: begin
`ifdef SRAM_POSTED_WRITE_EN
                ready = write_en | ~read_en;
`else
                ready = ~req;
`endif
                if (req) begin
                    state_d    = ACCESS;
                    addr_d     = sram_word_addr(address, BASE_ADDR);
                    data_d     = write_data;
                    is_write_d = write_en;  // write wins when both are raised
                end
            end
            ACCESS: begin
                if (last) begin
`ifdef SRAM_POSTED_WRITE_EN
                    // Posted writes were already acknowledged; skip the DONE pulse.
                    state_d = is_write_q ? IDLE : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            is_write_q <= is_write_d;
            if (in_access && last && !is_write_q) begin
                rdata_q <= SRAM_DQ;
            end
        end
    end

    assign drive_dq  = in_access && is_write_q;
    assign SRAM_WE_N = ~drive_dq;
    assign SRAM_DQ   = drive_dq ? data_q : 'z;
    assign SRAM_ADDR = addr_q;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Randomised bench for sram_controller with a behavioural SRAM array and a cycle-numbered
// reference of each access; honours SRAM_POSTED_WRITE_EN when defined.
module tb_sram_controller;

    localparam int unsigned WAIT = 5;
    localparam logic [31:0] BASE = 32'd1024;
`ifdef SRAM_POSTED_WRITE_EN
    localparam bit Posted = 1'b1;
`else
    localparam bit Posted = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en, read_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [16:0] SRAM_ADDR;
    wire  [31:0] SRAM_DQ;
    logic        SRAM_WE_N;
    logic        sram_oe;

    logic [31:0] mem [0:131071];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rdata;
    int          n_checks = 0;
    int          n_errors = 0;

    sram_controller #(
        .WAIT_CYCLES (WAIT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .read_en    (read_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    always #5 clk = ~clk;

    // Async SRAM: bench drives the bus only while it expects a read.
    assign SRAM_DQ = (sram_oe && SRAM_WE_N) ? mem[SRAM_ADDR] : 'z;

    function automatic logic [31:0] init_val(input logic [16:0] w);
        return ({15'h0, w} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [16:0] word_of(input logic [31:0] addr);
        return 17'((addr - BASE) >> 2);
    endfunction

    function automatic logic [31:0] ref_read(input logic [16:0] w);
        if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
        return init_val(w);
    endfunction

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = init_val(17'(i));
        forever begin
            @(posedge clk);
            if (!SRAM_WE_N) mem[SRAM_ADDR] = SRAM_DQ;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered just after a negedge (cycle 0 of the request); leaves at the next idle cycle.
    task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] data, input int drop_at);
        logic [16:0] w;
        bit          posted;
        int          last_c;
        w      = word_of(addr);
        posted = Posted && wr;
        last_c = posted ? WAIT : WAIT + 1;
        write_en   = wr;
        read_en    = rd;
        address    = addr;
        write_data = data;
        sram_oe    = rd && !wr;
        for (int c = 0; c <= last_c; c++) begin
            if (c == drop_at || (posted && c == 1)) begin
                write_en = 1'b0;
                read_en  = 1'b0;
            end
            #1;
            check_eq("ready", 32'(ready), 32'(posted ? (c == 0) : (c == last_c)));
            if (c >= 1) begin
                check_eq("sram_addr", 32'(SRAM_ADDR), 32'(w));
                check_eq("we_n", 32'(SRAM_WE_N), 32'(!(wr && c <= WAIT)));
                if (wr && c <= WAIT) check_eq("dq_write", SRAM_DQ, data);
            end
            if (c == last_c) begin
                if (!wr) exp_rdata = ref_read(w);
                check_eq("read_data", read_data, exp_rdata);
                write_en = 1'b0;
                read_en  = 1'b0;
            end
            @(negedge clk);
        end
        sram_oe = 1'b0;
        if (wr) begin
            ref_mem[int'(w)] = data;
            check_eq("sram_cell", mem[w], data);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        rst        = 1'b0;
        write_en   = 1'b1;
        read_en    = 1'b1;
        address    = 32'd1028;
        write_data = 32'h1234_5678;
        sram_oe    = 1'b0;
        exp_rdata  = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check_eq("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check_eq("rst_rdata", read_data, 32'd0);
        check_eq("rst_ready_req", 32'(ready), 32'(Posted));
        write_en = 1'b0;
        read_en  = 1'b0;
        #1;
        check_eq("rst_ready_idle", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed: basic write/read, address map, back-to-back.
        access(1, 0, 32'd1028, 32'hDEAD_BEEF, -1);
        check_eq("word1", mem[1], 32'hDEAD_BEEF);
        access(0, 1, 32'd1028, '0, -1);
        check_eq("rd_deadbeef", exp_rdata, 32'hDEAD_BEEF);
        access(1, 0, 32'd1024, 32'h0BAD_F00D, -1);
        access(1, 0, 32'd1020, 32'hFFFF_0001, -1);
        check_eq("wrap_word", mem[17'h1FFFF], 32'hFFFF_0001);
        access(0, 1, 32'd1027, '0, -1);
        access(1, 0, 32'd1032, 32'hA5A5_0F0F, -1);
        access(0, 1, 32'd1032, '0, -1);
        // Write wins over a simultaneous read; read_data must not move.
        access(1, 1, 32'd1036, 32'h7777_1111, -1);
        // Request dropped mid-access still completes.
        access(0, 1, 32'd1020, '0, 2);

        // Reset in cycle 3 of a write aborts immediately.
        write_en   = 1'b1;
        address    = BASE + 32'h0004_0000;
        write_data = 32'h5555_AAAA;
        repeat (3) @(negedge clk);
        #1;
        rst      = 1'b0;
        write_en = 1'b0;
        #1;
        check_eq("abort_we_n", 32'(SRAM_WE_N), 32'd1);
        check_eq("abort_addr", 32'(SRAM_ADDR), 32'd0);
        check_eq("abort_ready", 32'(ready), 32'd1);
        check_eq("abort_rdata", read_data, 32'd0);
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(0, 1, 32'd1028, '0, -1);

        if (Posted) begin
            // Posted write, then a read issued during the drain.
            write_en   = 1'b1;
            address    = BASE + 32'd64;
            write_data = 32'hCAFE_F00D;
            #1;
            check_eq("post_ready0", 32'(ready), 32'd1);
            @(negedge clk);
            write_en = 1'b0;
            read_en  = 1'b1;
            sram_oe  = 1'b1;
            for (int c = 1; c <= 2 * WAIT + 2; c++) begin
                #1;
                check_eq("post_rd_ready", 32'(ready), 32'(c == 2 * WAIT + 2));
                if (c == 2 * WAIT + 2) begin
                    check_eq("post_rd_data", read_data, 32'hCAFE_F00D);
                    read_en = 1'b0;
                end
                @(negedge clk);
            end
            sram_oe = 1'b0;
            ref_mem[16] = 32'hCAFE_F00D;
            exp_rdata   = 32'hCAFE_F00D;
        end

        // Random mix over a small word pool, including the wrapped region below BASE.
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) a = BASE - 32'($urandom_range(1, 8) * 4);
            else a = BASE + 32'($urandom_range(0, 15) * 4);
            a  = a + 32'($urandom_range(0, 3));
            op = int'($urandom_range(0, 5));
            access(op < 2, op >= 2 || op == 1, a, $urandom,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WAIT)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
